// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem request, fetch FIFO
//
// Purpose:
//   Owns the fetch PC and issues one-word requests to instruction memory
//   over a req/gnt/rvalid handshake with variable latency. Returned words
//   are buffered with their PCs in a small FIFO whose head drives the
//   IF/ID register. Handles downstream stall and branch/jump redirect,
//   and discards wrong-path responses.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall                 downstream cannot advance; FIFO head is held
//   redirect, redirect_pc taken branch/jump; flush and refetch from redirect_pc
//   imem_req, imem_addr   fetch request and its word address
//   imem_gnt              memory accepts the request this cycle
//   imem_rvalid/rdata     in-order response word
//   code, pc, valid       instruction, its PC and valid flag towards IF/ID

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] code,
    output logic [31:0] pc,
    output logic        valid
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FQ_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q,   req_pc_d;
    logic             outst_q,    outst_d;
    logic             drop_q,     drop_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic [31:0] fq_pc_q   [FQ_DEPTH];
    logic [31:0] fq_code_q [FQ_DEPTH];

    logic           grant;
    logic           resp;
    logic           push;
    logic           pop;
    logic [CNT_W:0] inflight;
    logic           unused_rpc_lsbs;

    assign unused_rpc_lsbs = ^redirect_pc[1:0];

    // An outstanding request already owns a FIFO slot, so it counts
    // against the credit; this is what makes overflow impossible.
    assign inflight = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(outst_q);

    // A new request may overlap the cycle in which the previous one returns.
    assign imem_req  = !reset && !redirect && (!outst_q || imem_rvalid) && (inflight < DEPTH_L);
    assign imem_addr = fetch_pc_q;

    assign grant = imem_req && imem_gnt;
    assign resp  = imem_rvalid && outst_q;
    assign push  = resp && !drop_q && !redirect;
    assign valid = (count_q != '0);
    assign pop   = valid && !stall && !redirect;

    assign code = valid ? fq_code_q[rd_ptr_q] : 32'h0;
    assign pc   = valid ? fq_pc_q[rd_ptr_q]   : 32'h0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            if (outst_q) begin
                if (imem_rvalid) begin
                    // The wrong-path word is arriving right now; just discard it.
                    outst_d = 1'b0;
                    drop_d  = 1'b0;
                end else begin
                    // Keep the slot busy until the stale word comes back.
                    drop_d = 1'b1;
                end
            end
        end else begin
            if (grant) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
                outst_d    = 1'b1;
            end else if (resp) begin
                outst_d = 1'b0;
            end

            if (resp && drop_q) begin
                drop_d = 1'b0;
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            outst_q    <= 1'b0;
            drop_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fq_pc_q[wr_ptr_q]   <= req_pc_q;
            fq_code_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit

module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 4;
    localparam logic [31:0] MASK     = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] code;
    logic [31:0] pc;
    logic        valid;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .code        (code),
        .pc          (pc),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int lat   = 1;

    logic [31:0] exp_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs at the falling edge, let the memory
    // model react to the rising edge, then present the next response.
    task automatic run_cycle();
        logic        granted;
        logic        rv_seen;
        logic [31:0] gaddr;
        logic [31:0] e;
        @(negedge clk);
        if (!reset && valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_pc", pc, e);
                check_eq("out_code", code, e ^ MASK);
            end
        end
        if (!valid) begin
            check_eq("idle_pc", pc, 32'h0);
            check_eq("idle_code", code, 32'h0);
        end
        granted = imem_req && imem_gnt;
        gaddr   = imem_addr;
        rv_seen = imem_rvalid;
        @(posedge clk);
        #1;
        if (rv_seen) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (granted) begin
            mem_addr_q.push_back(gaddr);
            mem_due_q.push_back(cyc + lat);
        end
        cyc++;
        if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_addr_q[0] ^ MASK;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic drain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            run_cycle();
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        exp_q.delete();
        repeat (n) run_cycle();
        check_eq("rst_req", {31'h0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'h0, valid}, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rst_req_release", {31'h0, imem_req}, 32'd1);
        check_eq("rst_addr", imem_addr, RESET_PC);
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        // 1: one-cycle memory, streaming
        lat = 1;
        do_reset(3);
        for (int i = 0; i < 64; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
        run_cycle();
        check_eq("t1_not_yet_valid", {31'h0, valid}, 32'd0);
        run_cycle();
        check_eq("t1_first_valid", {31'h0, valid}, 32'd1);
        check_eq("t1_first_pc", pc, RESET_PC);
        for (int i = 0; i < 12; i++) begin
            run_cycle();
            check_eq("t1_stream", {31'h0, valid}, 32'd1);
        end

        // 2: stall holds the head, fetching stops once credits run out
        do_reset(3);
        for (int i = 0; i < 32; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
        run_cycle();
        run_cycle();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            check_eq("t2_frozen_pc", pc, RESET_PC);
            check_eq("t2_frozen_valid", {31'h0, valid}, 32'd1);
        end
        check_eq("t2_req_off", {31'h0, imem_req}, 32'd0);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            check_eq("t2_nogap", {31'h0, valid}, 32'd1);
        end
        check_eq("t2_next_head", pc, RESET_PC + 32'd20);

        // 3: three-cycle memory, redirect while 0x8 is outstanding
        lat = 3;
        do_reset(3);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        drain("t3_pre_drain", 30);
        check_eq("t3_inflight_addr", mem_addr_q.size() != 0 ? mem_addr_q[0] : 32'hFFFF_FFFF, 32'h8);
        check_eq("t3_no_rvalid", {31'h0, imem_rvalid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        exp_q.delete();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        #1;
        check_eq("t3_req_redirect", {31'h0, imem_req}, 32'd0);
        run_cycle();
        redirect = 1'b0;
        check_eq("t3_flushed", {31'h0, valid}, 32'd0);
        drain("t3_drain", 40);

        // 4: redirect coinciding with rvalid and stall, unaligned target
        lat = 1;
        do_reset(3);
        exp_q.push_back(32'h0);
        run_cycle();
        run_cycle();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        check_eq("t4_rvalid_coincident", {31'h0, imem_rvalid}, 32'd1);
        exp_q.delete();
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        run_cycle();
        redirect = 1'b0;
        stall    = 1'b0;
        check_eq("t4_empty", {31'h0, valid}, 32'd0);
        check_eq("t4_addr", imem_addr, 32'h200);
        drain("t4_drain", 20);

        // 5: PC wraps past the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        run_cycle();
        redirect = 1'b0;
        drain("t5_drain", 20);

        // 6: reset with a full FIFO and a request in flight
        lat = 3;
        do_reset(3);
        stall = 1'b1;
        repeat (11) run_cycle();
        check_eq("t6_full_valid", {31'h0, valid}, 32'd1);
        check_eq("t6_full_req", {31'h0, imem_req}, 32'd0);
        check_eq("t6_one_outstanding", 32'(mem_addr_q.size()), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        run_cycle();
        reset    = 1'b0;
        imem_gnt = 1'b0;
        check_eq("t6_rst_valid", {31'h0, valid}, 32'd0);
        for (int i = 0; i < 10 && mem_addr_q.size() != 0; i++) begin
            run_cycle();
            check_eq("t6_late_ignored", {31'h0, valid}, 32'd0);
        end
        check_eq("t6_late_delivered", 32'(mem_addr_q.size()), 32'd0);
        imem_gnt = 1'b1;
        stall    = 1'b0;
        exp_q.push_back(RESET_PC);
        exp_q.push_back(RESET_PC + 32'd4);
        exp_q.push_back(RESET_PC + 32'd8);
        drain("t6_drain", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
